// File: rtl/adf4158_pkg.sv
// Shared constants, state encoding and bank-index decode for the ADF4158
// configuration-interface receiver.
package adf4158_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 10;
    localparam int CTRL_W    = 3;
    localparam int IDX_W     = 4;
    localparam int CNT_W     = 6;

    // Bit positions inside a device word
    localparam int RAMP_EN_BIT  = 31;  // R0: ramp enable
    localparam int DEV_SEL_BIT  = 23;  // R5: deviation-word select
    localparam int STEP_SEL_BIT = 23;  // R6: step-word select

    // Shadow-bank index of each device word
    localparam logic [IDX_W-1:0] IDX_R0   = 4'd0;
    localparam logic [IDX_W-1:0] IDX_R1   = 4'd1;
    localparam logic [IDX_W-1:0] IDX_R2   = 4'd2;
    localparam logic [IDX_W-1:0] IDX_R3   = 4'd3;
    localparam logic [IDX_W-1:0] IDX_R4   = 4'd4;
    localparam logic [IDX_W-1:0] IDX_R5_0 = 4'd5;
    localparam logic [IDX_W-1:0] IDX_R5_1 = 4'd6;
    localparam logic [IDX_W-1:0] IDX_R6_0 = 4'd7;
    localparam logic [IDX_W-1:0] IDX_R6_1 = 4'd8;
    localparam logic [IDX_W-1:0] IDX_R7   = 4'd9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } rx_state_t;

    // Map a received word onto its shadow-bank slot. R5 and R6 each hold two
    // words distinguished by bit 23.
    function automatic logic [IDX_W-1:0] decode_idx(input logic [WORD_W-1:0] w);
        logic [IDX_W-1:0] idx;
        case (w[CTRL_W-1:0])
            3'd0:    idx = IDX_R0;
            3'd1:    idx = IDX_R1;
            3'd2:    idx = IDX_R2;
            3'd3:    idx = IDX_R3;
            3'd4:    idx = IDX_R4;
            3'd5:    idx = w[DEV_SEL_BIT]  ? IDX_R5_1 : IDX_R5_0;
            3'd6:    idx = w[STEP_SEL_BIT] ? IDX_R6_1 : IDX_R6_0;
            default: idx = IDX_R7;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/adf4158_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with single-cycle
// rise/fall pulses derived from the last two synchronised samples.
module adf4158_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchroniser chain plus one history flop for edge detection
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample the old value
        // of its neighbour, so the chain shifts one stage per clock.
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/adf4158_spi_rx.sv
// ADF4158 three-wire (sclk/sdata/le) receiver: oversamples the interface on
// clk, deserialises 32-bit words, decodes the target register and keeps a
// shadow bank of all ten device words.
// Optional: define ADF4158_SPI_RX_ERR_CNT_EN to add a saturating 8-bit
// err_count output that counts rejected frames.
module adf4158_spi_rx
    import adf4158_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int BANK_DEPTH  = NUM_WORDS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk,
    input  logic                 sdata,
    input  logic                 le,
    output logic                 word_valid,
    output logic [WORD_W-1:0]    word,
    output logic [IDX_W-1:0]     word_idx,
    output logic                 frame_err,
    output logic [NUM_WORDS-1:0] loaded_mask,
    output logic                 all_loaded,
    output logic                 ramp_en,
    input  logic [IDX_W-1:0]     rd_addr,
    output logic [WORD_W-1:0]    rd_data
`ifdef ADF4158_SPI_RX_ERR_CNT_EN
    ,
    output logic [7:0]           err_count
`endif
);

    logic sclk_rise;
    logic sclk_fall_unused;
    logic sclk_level_unused;
    logic le_rise;
    logic le_fall;
    logic le_level_unused;
    logic sdata_s;
    logic sdata_rise_unused;
    logic sdata_fall_unused;

    adf4158_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk      (clk),
        .rst      (rst),
        .async_in (sclk),
        .level    (sclk_level_unused),
        .rise     (sclk_rise),
        .fall     (sclk_fall_unused)
    );

    adf4158_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_le (
        .clk      (clk),
        .rst      (rst),
        .async_in (le),
        .level    (le_level_unused),
        .rise     (le_rise),
        .fall     (le_fall)
    );

    // Same depth as sclk, so sdata_s is aligned with the sclk edge sample
    adf4158_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
        .clk      (clk),
        .rst      (rst),
        .async_in (sdata),
        .level    (sdata_s),
        .rise     (sdata_rise_unused),
        .fall     (sdata_fall_unused)
    );

    rx_state_t         state_q, state_n;
    logic [CNT_W-1:0]  count_q, count_n;
    logic [WORD_W-1:0] shift_q, shift_n;
    logic              commit_fire;
    logic              commit_ok;
    logic              commit_bad;
    logic [IDX_W-1:0]  commit_idx;

    logic [WORD_W-1:0] bank [BANK_DEPTH];

    // Next-state, shift and commit decisions. The commit is resolved on the
    // cycle le rises, using the count/shift already updated by any sclk edge
    // in that same cycle; COMMIT is the one-cycle settle state that follows.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_n     = state_q;
        count_n     = count_q;
        shift_n     = shift_q;
        commit_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (le_fall) begin
                    state_n = SHIFT;
                    count_n = '0;
                    shift_n = '0;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    shift_n = {shift_q[WORD_W-2:0], sdata_s};
                    if (count_q != '1) begin
                        count_n = count_q + 6'd1;
                    end
                end
                if (le_rise) begin
                    state_n     = COMMIT;
                    commit_fire = 1'b1;
                end
            end
            COMMIT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        commit_ok  = commit_fire && (count_n == 6'(WORD_W));
        commit_bad = commit_fire && !commit_ok;
        commit_idx = decode_idx(shift_n);
    end

    // State, bit counter and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_n;
            count_q <= count_n;
            shift_q <= shift_n;
        end
    end

    // Shadow bank write on a good commit
    always_ff @(posedge clk) begin
        // NOTE: the bank is explicitly cleared on reset because it is a
        // visible shadow of device state (ramp_en, rd_data), not scratch RAM.
        if (rst) begin
            for (int i = 0; i < BANK_DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (commit_ok) begin
            bank[commit_idx] <= shift_n;
        end
    end

    // Committed-word outputs, status pulses and load tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            word_valid  <= 1'b0;
            frame_err   <= 1'b0;
            word        <= '0;
            word_idx    <= '0;
            loaded_mask <= '0;
            all_loaded  <= 1'b0;
        end else begin
            word_valid <= commit_ok;
            frame_err  <= commit_bad;
            all_loaded <= &loaded_mask;
            if (commit_ok) begin
                word                    <= shift_n;
                word_idx                <= commit_idx;
                loaded_mask[commit_idx] <= 1'b1;
            end
        end
    end

    // Registered read port; a same-cycle write is not forwarded
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_addr < 4'(BANK_DEPTH)) begin
            rd_data <= bank[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

    assign ramp_en = bank[IDX_R0][RAMP_EN_BIT];

`ifdef ADF4158_SPI_RX_ERR_CNT_EN
    // Saturating count of rejected frames, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (commit_bad && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adf4158_spi_rx.sv
// Directed self-checking bench for adf4158_spi_rx at a clk/sclk ratio of 4.
module tb_adf4158_spi_rx;

    logic        clk;
    logic        rst;
    logic        sclk;
    logic        sdata;
    logic        le;
    logic        word_valid;
    logic [31:0] word;
    logic [3:0]  word_idx;
    logic        frame_err;
    logic [9:0]  loaded_mask;
    logic        all_loaded;
    logic        ramp_en;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
`ifdef ADF4158_SPI_RX_ERR_CNT_EN
    logic [7:0]  err_count;
`endif

    int checks   = 0;
    int failures = 0;
    int wv_cnt   = 0;
    int fe_cnt   = 0;

    adf4158_spi_rx #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .sdata       (sdata),
        .le          (le),
        .word_valid  (word_valid),
        .word        (word),
        .word_idx    (word_idx),
        .frame_err   (frame_err),
        .loaded_mask (loaded_mask),
        .all_loaded  (all_loaded),
        .ramp_en     (ramp_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
`ifdef ADF4158_SPI_RX_ERR_CNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (word_valid === 1'b1) wv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic start_frame();
        le = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sdata = v[i];
            repeat (2) @(negedge clk);
            sclk = 1'b1;
            repeat (2) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    // Raise le and wait (bounded) for the resulting pulse
    task automatic end_frame(output int lat, output logic v, output logic e,
                             output logic al, output logic al_next, output logic r);
        le      = 1'b1;
        lat     = 0;
        v       = 1'b0;
        e       = 1'b0;
        al      = 1'b0;
        al_next = 1'b0;
        r       = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (word_valid === 1'b1 || frame_err === 1'b1) begin
                lat = i;
                v   = word_valid;
                e   = frame_err;
                al  = all_loaded;
                r   = ramp_en;
                break;
            end
        end
        @(negedge clk);
        al_next = all_loaded;
        repeat (3) @(negedge clk);
    endtask

    task automatic send(input logic [63:0] v, input int n, output int lat, output logic ok,
                        output logic err, output logic al, output logic al_next, output logic r);
        start_frame();
        shift_bits(v, n);
        end_frame(lat, ok, err, al, al_next, r);
    endtask

    task automatic read_bank(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        d = rd_data;
    endtask

    logic [31:0] seq_words [10];
    logic [3:0]  seq_idx   [10];

    initial begin
        int          lat;
        logic        ok, err, al, al_next, r;
        logic [31:0] d;
        int          wv0, fe0;

        rst = 1'b1; sclk = 1'b0; sdata = 1'b0; le = 1'b1; rd_addr = 4'd0;
        seq_words = '{32'h1234_0007, 32'h0080_0E06, 32'h0000_0AB6, 32'h0080_1235,
                      32'h0040_0A5D, 32'h0018_0104, 32'h0000_0443, 32'h0040_8002,
                      32'h0000_0001, 32'hF800_0008};
        seq_idx   = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_word_valid", 32'(word_valid), 32'd0);
        check("rst_word", word, 32'd0);
        check("rst_word_idx", 32'(word_idx), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_loaded_mask", 32'(loaded_mask), 32'd0);
        check("rst_all_loaded", 32'(all_loaded), 32'd0);
        check("rst_ramp_en", 32'(ramp_en), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("idle_le_rise_ignored", 32'(fe_cnt), 32'd0);

        // R0 frame with ramp enable set
        wv0 = wv_cnt;
        send(64'h8422_1000, 32, lat, ok, err, al, al_next, r);
        check("r0_latency", 32'(lat), 32'd3);
        check("r0_valid", 32'(ok), 32'd1);
        check("r0_err", 32'(err), 32'd0);
        check("r0_ramp_at_valid", 32'(r), 32'd1);
        check("r0_word", word, 32'h8422_1000);
        check("r0_word_idx", 32'(word_idx), 32'd0);
        check("r0_pulse_count", 32'(wv_cnt - wv0), 32'd1);
        read_bank(4'd0, d);
        check("r0_bank", d, 32'h8422_1000);

        // R5 sub-register select
        do_reset();
        check("rst2_loaded_mask", 32'(loaded_mask), 32'd0);
        check("rst2_ramp_en", 32'(ramp_en), 32'd0);
        read_bank(4'd0, d);
        check("rst2_bank0", d, 32'd0);
        send(64'h0080_0005, 32, lat, ok, err, al, al_next, r);
        check("r5_1_idx", 32'(word_idx), 32'd6);
        send(64'h0000_0005, 32, lat, ok, err, al, al_next, r);
        check("r5_0_idx", 32'(word_idx), 32'd5);
        check("r5_mask", 32'(loaded_mask), 32'h060);
        read_bank(4'd6, d);
        check("r5_bank6", d, 32'h0080_0005);
        read_bank(4'd5, d);
        check("r5_bank5", d, 32'h0000_0005);

        // Short and overlong frames are rejected
        wv0 = wv_cnt;
        fe0 = fe_cnt;
        send(64'h1234_5675, 31, lat, ok, err, al, al_next, r);
        check("short_latency", 32'(lat), 32'd3);
        check("short_err", 32'(err), 32'd1);
        check("short_valid", 32'(ok), 32'd0);
        send(64'h1_1234_5675, 33, lat, ok, err, al, al_next, r);
        check("long_err", 32'(err), 32'd1);
        check("long_valid", 32'(ok), 32'd0);
        check("bad_no_valid", 32'(wv_cnt - wv0), 32'd0);
        check("bad_err_pulses", 32'(fe_cnt - fe0), 32'd2);
        check("bad_word_held", word, 32'h0000_0005);
        check("bad_mask_held", 32'(loaded_mask), 32'h060);
        read_bank(4'd5, d);
        check("bad_bank5_held", d, 32'h0000_0005);

        // Full load, R7 down to R0
        do_reset();
        for (int k = 0; k < 10; k++) begin
            send({32'd0, seq_words[k]}, 32, lat, ok, err, al, al_next, r);
            check($sformatf("seq%0d_valid", k), 32'(ok), 32'd1);
            check($sformatf("seq%0d_idx", k), 32'(word_idx), 32'(seq_idx[k]));
            if (k == 9) begin
                check("seq_all_loaded_at_valid", 32'(al), 32'd0);
                check("seq_all_loaded_next", 32'(al_next), 32'd1);
            end
        end
        check("seq_mask", 32'(loaded_mask), 32'h3FF);
        check("seq_ramp_en", 32'(ramp_en), 32'd1);
        for (int k = 0; k < 10; k++) begin
            read_bank(seq_idx[k], d);
            check($sformatf("seq_bank%0d", seq_idx[k]), d, seq_words[k]);
        end
        read_bank(4'd10, d);
        check("rd_addr_10", d, 32'd0);
        read_bank(4'd15, d);
        check("rd_addr_15", d, 32'd0);

        // Reset in the middle of a frame
        fe0 = fe_cnt;
        start_frame();
        shift_bits(64'h0000_ABCD, 16);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        le = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_no_err", 32'(fe_cnt - fe0), 32'd0);
        check("midrst_mask", 32'(loaded_mask), 32'd0);
        check("midrst_word", word, 32'd0);
        send(64'h0000_0443, 32, lat, ok, err, al, al_next, r);
        check("midrst_next_valid", 32'(ok), 32'd1);
        check("midrst_next_mask", 32'(loaded_mask), 32'h008);
        read_bank(4'd3, d);
        check("midrst_next_bank3", d, 32'h0000_0443);

`ifdef ADF4158_SPI_RX_ERR_CNT_EN
        // Saturating error counter
        do_reset();
        check("errcnt_reset", 32'(err_count), 32'd0);
        for (int k = 0; k < 260; k++) begin
            send(64'h1, 1, lat, ok, err, al, al_next, r);
        end
        check("errcnt_sat", 32'(err_count), 32'd255);
        send(64'h1, 1, lat, ok, err, al, al_next, r);
        check("errcnt_held", 32'(err_count), 32'd255);
        do_reset();
        check("errcnt_cleared", 32'(err_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adf4158_spi_rx.md
Name: adf4158_spi_rx

Overview:
- Receiving end of the ADF4158 three-wire configuration interface (sclk/data/le), oversampled on a single fabric clock.
- Deserialises 32-bit words and decodes the control bits (low 3 bits, plus the R5/R6 sub-register select bits).
- Holds a shadow of all ten device words in a register bank.
- Used as an on-FPGA loopback monitor and bench checker for the ADF4158 configuration writer: confirms what the device was actually told, including ramp_en toggles.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each asynchronous serial input (minimum 2).
- BANK_DEPTH, 10, number of shadow words. Fixed by the register map; not meant to be overridden.

Ports:
- clk  input  1  fabric clock; must be at least 4x the sclk frequency.
- rst  input  1  reset, synchronous, active-high.
- sclk  input  1  serial clock from the writer; asynchronous to clk.
- sdata  input  1  serial data, MSB first; asynchronous.
- le  input  1  load enable: low while shifting, rising edge commits; asynchronous.
- word_valid  output  1  one-cycle pulse when a word is committed.
- word  output  32  last committed word; held between commits.
- word_idx  output  4  bank index of the last committed word.
- frame_err  output  1  one-cycle pulse when a frame is rejected.
- loaded_mask  output  10  bit i is set once bank index i has been written.
- all_loaded  output  1  high when loaded_mask == 10'h3FF.
- ramp_en  output  1  bank[0][31].
- rd_addr  input  4  bank read index.
- rd_data  output  32  registered bank read data.

Behaviour:
- Reset (synchronous, rst=1):
  - State goes to IDLE; bit counter and shift register clear to 0.
  - All bank words are 0.
  - All outputs are 0: word_valid, word, word_idx, frame_err, loaded_mask, all_loaded, ramp_en, rd_data.
  - Reset mid-frame discards the partial word; no frame_err is raised.
- Input conditioning:
  - sclk, sdata and le each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last two synchronised samples.
  - sdata is taken from the same synchronised stage as the sclk edge sample.
- State machine:
  - IDLE: wait for le falling edge, then go to SHIFT with count=0.
  - SHIFT: on each sclk rising edge, shift = {shift[30:0], sdata_s} and count += 1. Count saturates at 63.
  - SHIFT -> COMMIT on le rising edge.
  - COMMIT lasts one cycle and always returns to IDLE.
- Same-cycle sclk rise and le rise: the bit is shifted first, then the word is committed with the updated count.
- COMMIT when count == 32:
  - Decode the bank index:
    - ctrl 0..4 -> index 0..4.
    - ctrl 5 -> index 5 if bit23 == 0, else 6.
    - ctrl 6 -> index 7 if bit23 == 0, else 8.
    - ctrl 7 -> index 9.
  - Write the bank, set the loaded_mask bit, and update word and word_idx.
  - Pulse word_valid for 1 cycle; it is asserted the cycle after the le edge is detected.
- COMMIT when count != 32 (short or overlong frame): no bank change; pulse frame_err for 1 cycle.
- le rising edge while in IDLE is ignored.
- Read port:
  - rd_data = bank[rd_addr], registered, 1-cycle latency.
  - rd_addr > 9 returns 0.
  - A read of the index being committed in the same cycle returns the old value.
- ramp_en follows bank[0] combinationally from the register, so it updates on the same cycle as word_valid.

Optional Feature:
- Macro: ADF4158_SPI_RX_ERR_CNT_EN.
- When defined:
  - Adds output port err_count (8 bits), reset to 0.
  - err_count increments on every frame_err and saturates at 255.
  - It clears only on rst.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package adf4158_pkg holds:
  - WORD_W=32, NUM_WORDS=10, CTRL_W=3.
  - Bit positions: RAMP_EN_BIT=31, DEV_SEL_BIT=23, STEP_SEL_BIT=23.
  - Bank index constants IDX_R0..IDX_R4, IDX_R5_0, IDX_R5_1, IDX_R6_0, IDX_R6_1, IDX_R7.
  - State encoding IDLE/SHIFT/COMMIT.
- Sub-module adf4158_sync_edge: SYNC_STAGES synchroniser with rise/fall pulse outputs. It is instantiated for sclk, le and sdata; only the level output is used for sdata.

Test Plan:
- 32-bit frame 0x8422_1000 (ctrl 0) -> word_valid pulse, word_idx=0, rd_addr=0 returns 0x8422_1000 one cycle later, ramp_en=1.
- Frames 0x0080_0005 then 0x0000_0005 -> banks 6 and 5 written separately; loaded_mask=0x060.
- 31-bit frame, then 33-bit frame -> two frame_err pulses, bank unchanged, word_valid never asserted.
- Full sequence in order R7, R6_1, R6_0, R5_1, R5_0, R4, R3, R2, R1, R0 at a clk/sclk ratio of 4 -> all_loaded rises the cycle after the last word_valid; each bank word equals its sent word.
- rst pulsed after 16 bits of a frame -> IDLE, loaded_mask=0, no frame_err; a following full frame is accepted.
- With ADF4158_SPI_RX_ERR_CNT_EN defined: 260 short frames -> err_count=255, held; rst -> 0.
